backbone_initial_seq: RTL



---
 rtl/backbone_pkg.sv | 20 ++
 rtl/fx_mul_sat.sv | 27 ++
 rtl/backbone_initial_seq.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/backbone_pkg.sv
// Shared state encoding and fixed-point helpers for the backbone initial-product generator.
package backbone_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Fixed-point 1.0 for a given number of fractional bits.
    function automatic logic [63:0] fx_one(input int frac);
        return 64'd1 << frac;
    endfunction

    // One spare bit so out-of-alphabet symbols stay representable and detectable.
    function automatic int a_width(input int a);
        return $clog2(a) + 1;
    endfunction

endpackage

// File: rtl/fx_mul_sat.sv
// Combinational acc*alpha, truncating right shift by DATA_FRAC, clamp to OUT_WIDTH with sat flag.
// Zero latency, no flow control.
module fx_mul_sat
    import backbone_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int DATA_FRAC  = 7,
    parameter int OUT_WIDTH  = 32
) (
    input  logic [OUT_WIDTH-1:0]  acc,
    input  logic [DATA_WIDTH-1:0] alpha,
    output logic [OUT_WIDTH-1:0]  res,
    output logic                  sat
);
    localparam int PW = OUT_WIDTH + DATA_WIDTH;

    logic [PW-1:0] prod;
    logic [PW-1:0] shifted;

    always_comb begin
        prod    = PW'(acc) * PW'(alpha);
        shifted = prod >> DATA_FRAC;
        sat     = |shifted[PW-1:OUT_WIDTH];
        res     = sat ? '1 : shifted[OUT_WIDTH-1:0];
    end

endmodule

// File: rtl/backbone_initial_seq.sv
// Backbone initial product over non-excluded variables, one shared multiplier, one variable per cycle; result J cycles after accept.
// din_tready only in IDLE or while a held DONE result is consumed; BACKBONE_SAT_FLAG_EN adds the sticky dout_sat port.
module backbone_initial_seq
    import backbone_pkg::*;
#(
    parameter int J          = 14,
    parameter int A          = 2,
    parameter int DATA_WIDTH = 8,
    parameter int DATA_FRAC  = 7,
    parameter int OUT_WIDTH  = 32,
    parameter int OUT_FRAC   = 16,
    localparam int A_WIDTH   = a_width(A)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [J*A*DATA_WIDTH-1:0] alpha_u,
    input  logic [J*A_WIDTH-1:0]      x_initial,
    input  logic [J-1:0]              excl_mask,
    input  logic                      din_tvalid,
    output logic                      din_tready,
    output logic [OUT_WIDTH-1:0]      dout,
    output logic                      dout_tvalid,
    input  logic                      dout_tready
`ifdef BACKBONE_SAT_FLAG_EN
    ,
    output logic                      dout_sat
`endif
);
    localparam int IDX_W = (J > 1) ? $clog2(J) : 1;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(J - 1);

    state_t                    state, state_nxt;
    logic                      accept;
    logic [J*A*DATA_WIDTH-1:0] alpha_r;
    logic [J*A_WIDTH-1:0]      x_r;
    logic [J-1:0]              mask_r;
    logic [IDX_W-1:0]          idx;
    logic [OUT_WIDTH-1:0]      acc, acc_nxt, mul_res;
    logic                      sat, sat_nxt, mul_sat;
    logic [A_WIDTH-1:0]        x_sel;
    logic [DATA_WIDTH-1:0]     alpha_sel;
    logic                      excl_sel;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = RUN;
            RUN:     if (idx == LAST) state_nxt = DONE;
            DONE:    if (dout_tready) state_nxt = accept ? RUN : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        din_tready = (state == IDLE) || (state == DONE && dout_tready);
        accept     = din_tvalid && din_tready;
    end

    // Operand mux for the current variable; out-of-alphabet symbols leave alpha_sel at zero.
    always_comb begin
        x_sel     = '0;
        excl_sel  = 1'b0;
        alpha_sel = '0;
        for (int j = 0; j < J; j++) begin
            if (idx == IDX_W'(j)) begin
                x_sel    = x_r[j*A_WIDTH +: A_WIDTH];
                excl_sel = mask_r[j];
                for (int a = 0; a < A; a++) begin
                    if (x_r[j*A_WIDTH +: A_WIDTH] == A_WIDTH'(a))
                        alpha_sel = alpha_r[(j*A + a)*DATA_WIDTH +: DATA_WIDTH];
                end
            end
        end
    end

    fx_mul_sat #(
        .DATA_WIDTH (DATA_WIDTH),
        .DATA_FRAC  (DATA_FRAC),
        .OUT_WIDTH  (OUT_WIDTH)
    ) u_mul (
        .acc   (acc),
        .alpha (alpha_sel),
        .res   (mul_res),
        .sat   (mul_sat)
    );

    always_comb begin
        acc_nxt = acc;
        sat_nxt = sat;
        if (!excl_sel) begin
            if (x_sel >= A_WIDTH'(A)) begin
                acc_nxt = '0;
            end else begin
                acc_nxt = mul_res;
                sat_nxt = sat | mul_sat;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alpha_r     <= '0;
            x_r         <= '0;
            mask_r      <= '0;
            acc         <= '0;
            sat         <= 1'b0;
            idx         <= '0;
            dout        <= '0;
            dout_tvalid <= 1'b0;
        end else if (accept) begin
            alpha_r     <= alpha_u;
            x_r         <= x_initial;
            mask_r      <= excl_mask;
            acc         <= OUT_WIDTH'(fx_one(OUT_FRAC));
            sat         <= 1'b0;
            idx         <= '0;
            dout_tvalid <= 1'b0;
        end else if (state == RUN) begin
            acc <= acc_nxt;
            sat <= sat_nxt;
            if (idx == LAST) begin
                dout        <= acc_nxt;
                dout_tvalid <= 1'b1;
            end else begin
                idx <= idx + IDX_W'(1);
            end
        end else if (state == DONE && dout_tready) begin
            dout_tvalid <= 1'b0;
        end
    end

`ifdef BACKBONE_SAT_FLAG_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                               dout_sat <= 1'b0;
        else if (state == RUN && idx == LAST)  dout_sat <= sat_nxt;
    end
`endif

endmodule
